// File: rtl/mult_bus_master.sv
// mult_bus_master: bus initiator that runs a 16x16 multiply job on the
// memory-mapped multiplier peripheral. The job comes in on a valid/ready
// request port. The block writes A and B, pulses init, polls done with a
// gap between polls, then reads the 32-bit product. It returns the product,
// or a timeout flag, on a valid/ready response port.
// Moore machine: every bus and handshake output decodes state_q and the
// datapath registers only. No input reaches an output combinationally.
module mult_bus_master #(
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int          POLL_GAP      = 4,
  parameter int          TIMEOUT_POLLS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_timeout,
  output logic        busy,
  output logic        bus_cs,
  output logic [31:0] bus_addr,
  output logic        bus_rd,
  output logic        bus_wr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata
);

  // Register offsets inside the peripheral window
  localparam logic [31:0] OFS_A    = 32'h04;
  localparam logic [31:0] OFS_B    = 32'h08;
  localparam logic [31:0] OFS_INIT = 32'h0C;
  localparam logic [31:0] OFS_RES  = 32'h10;
  localparam logic [31:0] OFS_DONE = 32'h14;

  // The poll counter must be able to hold TIMEOUT_POLLS itself
  localparam int PCW = $clog2(TIMEOUT_POLLS + 1);
  // The gap counter only needs to reach POLL_GAP-1
  localparam int GCW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  localparam logic [PCW-1:0] POLL_LAST = PCW'(TIMEOUT_POLLS - 1);
  localparam logic [GCW-1:0] GAP_LAST  = GCW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
  localparam bit             HAS_GAP   = (POLL_GAP > 0);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_WR_A     = 4'd1;
  localparam logic [3:0] S_WR_B     = 4'd2;
  localparam logic [3:0] S_INIT1    = 4'd3;
  localparam logic [3:0] S_INIT0    = 4'd4;
  localparam logic [3:0] S_GAP      = 4'd5;
  localparam logic [3:0] S_RD_DONE  = 4'd6;
  localparam logic [3:0] S_CHK_DONE = 4'd7;
  localparam logic [3:0] S_RD_RES   = 4'd8;
  localparam logic [3:0] S_CAP_RES  = 4'd9;
  localparam logic [3:0] S_RESP     = 4'd10;

  logic [3:0]     state_q,    state_d;
  logic [15:0]    a_q,        a_d;
  logic [15:0]    b_q,        b_d;
  logic [PCW-1:0] poll_cnt_q, poll_cnt_d;
  logic [GCW-1:0] gap_cnt_q,  gap_cnt_d;
  logic [31:0]    result_q,   result_d;
  logic           timeout_q,  timeout_d;

  // Choose the next state and update the datapath registers
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    poll_cnt_d = poll_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    result_d   = result_q;
    timeout_d  = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          a_d        = req_a;
          b_d        = req_b;
          poll_cnt_d = '0;
          gap_cnt_d  = '0;
          state_d    = S_WR_A;
        end
      end
      S_WR_A:  state_d = S_WR_B;
      S_WR_B:  state_d = S_INIT1;
      S_INIT1: state_d = S_INIT0;
      S_INIT0: begin
        gap_cnt_d = '0;
        state_d   = HAS_GAP ? S_GAP : S_RD_DONE;
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = S_RD_DONE;
        end else begin
          gap_cnt_d = gap_cnt_q + GCW'(1);
        end
      end
      S_RD_DONE: state_d = S_CHK_DONE;
      S_CHK_DONE: begin
        // The peripheral registers read data, so the done bit arrives here,
        // one cycle after the read strobe. Bits 31:1 are not meaningful.
        if (bus_rdata[0]) begin
          state_d = S_RD_RES;
        end else begin
          poll_cnt_d = poll_cnt_q + PCW'(1);
          if (poll_cnt_q == POLL_LAST) begin
            result_d  = '0;
            timeout_d = 1'b1;
            state_d   = S_RESP;
          end else begin
            gap_cnt_d = '0;
            state_d   = HAS_GAP ? S_GAP : S_RD_DONE;
          end
        end
      end
      S_RD_RES: state_d = S_CAP_RES;
      S_CAP_RES: begin
        result_d  = bus_rdata;
        timeout_d = 1'b0;
        state_d   = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any job in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      poll_cnt_q <= '0;
      gap_cnt_q  <= '0;
      result_q   <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      poll_cnt_q <= poll_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      result_q   <= result_d;
      timeout_q  <= timeout_d;
    end
  end

  // Decode the bus strobes and handshakes from the current state
  always_comb begin
    bus_cs    = 1'b0;
    bus_rd    = 1'b0;
    bus_wr    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    case (state_q)
      S_WR_A: begin
        bus_cs    = 1'b1;
        bus_wr    = 1'b1;
        bus_addr  = BASE_ADDR + OFS_A;
        bus_wdata = {16'b0, a_q};
      end
      S_WR_B: begin
        bus_cs    = 1'b1;
        bus_wr    = 1'b1;
        bus_addr  = BASE_ADDR + OFS_B;
        bus_wdata = {16'b0, b_q};
      end
      S_INIT1: begin
        bus_cs    = 1'b1;
        bus_wr    = 1'b1;
        bus_addr  = BASE_ADDR + OFS_INIT;
        bus_wdata = 32'h1;
      end
      S_INIT0: begin
        bus_cs    = 1'b1;
        bus_wr    = 1'b1;
        bus_addr  = BASE_ADDR + OFS_INIT;
        bus_wdata = 32'h0;
      end
      S_RD_DONE: begin
        bus_cs   = 1'b1;
        bus_rd   = 1'b1;
        bus_addr = BASE_ADDR + OFS_DONE;
      end
      S_RD_RES: begin
        bus_cs   = 1'b1;
        bus_rd   = 1'b1;
        bus_addr = BASE_ADDR + OFS_RES;
      end
      default: ;
    endcase
  end

  assign req_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_result  = result_q;
  assign rsp_timeout = timeout_q;

endmodule

// File: tb/tb_mult_bus_master.sv
// Directed bench for mult_bus_master. It uses two instances. Instance 0
// runs at base 0 with POLL_GAP=4 and TIMEOUT_POLLS=4. Instance 1 runs at a
// non-zero base with POLL_GAP=0. A behavioural peripheral answers both
// instances and logs their writes and reads.
module tb_mult_bus_master;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]       req_valid, rsp_ready;
  logic [1:0][15:0] req_a, req_b;
  logic [1:0][31:0] bus_rdata;
  wire  [1:0]       req_ready, rsp_valid, rsp_timeout, busy, bus_cs, bus_rd, bus_wr;
  wire  [1:0][31:0] rsp_result, bus_addr, bus_wdata;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mult_bus_master #(
      .BASE_ADDR    ((g == 0) ? 32'h0000_0000 : 32'h8000_1000),
      .POLL_GAP     ((g == 0) ? 4 : 0),
      .TIMEOUT_POLLS((g == 0) ? 4 : 1024)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_a      (req_a[g]),
      .req_b      (req_b[g]),
      .rsp_valid  (rsp_valid[g]),
      .rsp_ready  (rsp_ready[g]),
      .rsp_result (rsp_result[g]),
      .rsp_timeout(rsp_timeout[g]),
      .busy       (busy[g]),
      .bus_cs     (bus_cs[g]),
      .bus_addr   (bus_addr[g]),
      .bus_rd     (bus_rd[g]),
      .bus_wr     (bus_wr[g]),
      .bus_wdata  (bus_wdata[g]),
      .bus_rdata  (bus_rdata[g])
    );
  end

  // Peripheral model state; done_after = poll number where done first reads 1 (0 = never)
  int          done_after[2];
  int          polls[2], wr_cnt[2], n_rd_done[2], n_rd_res[2], act_cnt[2];
  logic [31:0] m_a[2], m_b[2], prod[2];
  logic [31:0] wr_addr[2][64], wr_data[2][64];

  function automatic logic [31:0] base_of(input int k);
    return (k == 0) ? 32'h0000_0000 : 32'h8000_1000;
  endfunction

  function automatic logic [31:0] offs(input int k);
    return bus_addr[k] - base_of(k);
  endfunction

  // Behavioural multiplier peripheral with registered read data
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bus_rdata[k] <= 32'hFFFF_FFFF;
      if (bus_cs[k]) act_cnt[k] <= act_cnt[k] + 1;
      if (bus_cs[k] && bus_wr[k]) begin
        wr_addr[k][wr_cnt[k] % 64] <= bus_addr[k];
        wr_data[k][wr_cnt[k] % 64] <= bus_wdata[k];
        wr_cnt[k] <= wr_cnt[k] + 1;
        if (offs(k) == 32'h04) m_a[k] <= bus_wdata[k];
        if (offs(k) == 32'h08) m_b[k] <= bus_wdata[k];
        if (offs(k) == 32'h0C && bus_wdata[k] == 32'h1) begin
          prod[k]  <= m_a[k] * m_b[k];
          polls[k] <= 0;
        end
      end
      if (bus_cs[k] && bus_rd[k]) begin
        if (offs(k) == 32'h14) begin
          polls[k]     <= polls[k] + 1;
          n_rd_done[k] <= n_rd_done[k] + 1;
          bus_rdata[k] <= {31'h2AAA_AAAA, (done_after[k] != 0 && polls[k] + 1 >= done_after[k])};
        end else if (offs(k) == 32'h10) begin
          n_rd_res[k]  <= n_rd_res[k] + 1;
          bus_rdata[k] <= prod[k];
        end
      end
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic chk_idle_bus(input int k, input string tag);
    chk({tag, "_cs"}, 32'(bus_cs[k]), 32'h0);
    chk({tag, "_rd"}, 32'(bus_rd[k]), 32'h0);
    chk({tag, "_wr"}, 32'(bus_wr[k]), 32'h0);
    chk({tag, "_addr"}, bus_addr[k], 32'h0);
    chk({tag, "_wdata"}, bus_wdata[k], 32'h0);
  endtask

  // Check the four setup writes logged from index s
  task automatic chk_writes(input int k, input int s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] base;
    base = base_of(k);
    chk("wr_a_addr", wr_addr[k][s % 64], base + 32'h04);
    chk("wr_a_data", wr_data[k][s % 64], a);
    chk("wr_b_addr", wr_addr[k][(s + 1) % 64], base + 32'h08);
    chk("wr_b_data", wr_data[k][(s + 1) % 64], b);
    chk("init1_addr", wr_addr[k][(s + 2) % 64], base + 32'h0C);
    chk("init1_data", wr_data[k][(s + 2) % 64], 32'h1);
    chk("init0_addr", wr_addr[k][(s + 3) % 64], base + 32'h0C);
    chk("init0_data", wr_data[k][(s + 3) % 64], 32'h0);
  endtask

  // Offer a job and hold it across the accept edge; returns in cycle 1
  task automatic start_job(input int k, input logic [15:0] a, input logic [15:0] b);
    req_a[k] = a;
    req_b[k] = b;
    req_valid[k] = 1'b1;
    chk("req_ready_before_accept", 32'(req_ready[k]), 32'h1);
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
  endtask

  // Count cycles from cycle 1 until rsp_valid is seen, bounded
  task automatic wait_rsp(input int k, output int cyc);
    cyc = 1;
    while (!rsp_valid[k] && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic consume(input int k);
    rsp_ready[k] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[k] = 1'b0;
    chk("rsp_valid_after_hs", 32'(rsp_valid[k]), 32'h0);
    chk("req_ready_after_hs", 32'(req_ready[k]), 32'h1);
  endtask

  int cyc, s, rd0, rr0, act0;

  initial begin
    reset = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    req_a = '0;
    req_b = '0;
    done_after[0] = 1;
    done_after[1] = 1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state of both instances
    for (int k = 0; k < 2; k++) begin
      chk("rst_req_ready", 32'(req_ready[k]), 32'h1);
      chk("rst_rsp_valid", 32'(rsp_valid[k]), 32'h0);
      chk("rst_rsp_result", rsp_result[k], 32'h0);
      chk("rst_rsp_timeout", 32'(rsp_timeout[k]), 32'h0);
      chk("rst_busy", 32'(busy[k]), 32'h0);
      chk_idle_bus(k, "rst");
    end

    // Job 3*5, done on the first poll
    s = wr_cnt[0]; rd0 = n_rd_done[0]; rr0 = n_rd_res[0];
    start_job(0, 16'd3, 16'd5);
    chk("t1_busy", 32'(busy[0]), 32'h1);
    chk("t1_req_ready_busy", 32'(req_ready[0]), 32'h0);
    wait_rsp(0, cyc);
    chk("t1_rsp_cycle", cyc, 13);
    chk("t1_result", rsp_result[0], 32'd15);
    chk("t1_timeout", 32'(rsp_timeout[0]), 32'h0);
    chk("t1_nwrites", wr_cnt[0] - s, 4);
    chk_writes(0, s, 32'h3, 32'h5);
    chk("t1_done_reads", n_rd_done[0] - rd0, 1);
    chk("t1_res_reads", n_rd_res[0] - rr0, 1);
    consume(0);

    // Done only on the third poll, full-scale operands
    done_after[0] = 3;
    rd0 = n_rd_done[0]; rr0 = n_rd_res[0];
    start_job(0, 16'hFFFF, 16'hFFFF);
    wait_rsp(0, cyc);
    chk("t2_rsp_cycle", cyc, 25);
    chk("t2_result", rsp_result[0], 32'hFFFE_0001);
    chk("t2_timeout", 32'(rsp_timeout[0]), 32'h0);
    chk("t2_done_reads", n_rd_done[0] - rd0, 3);
    chk("t2_res_reads", n_rd_res[0] - rr0, 1);
    consume(0);

    // Done stuck low: timeout after four polls
    done_after[0] = 0;
    rd0 = n_rd_done[0]; rr0 = n_rd_res[0];
    start_job(0, 16'd2, 16'd9);
    wait_rsp(0, cyc);
    chk("t3_rsp_cycle", cyc, 29);
    chk("t3_result", rsp_result[0], 32'h0);
    chk("t3_timeout", 32'(rsp_timeout[0]), 32'h1);
    chk("t3_done_reads", n_rd_done[0] - rd0, 4);
    chk("t3_res_reads", n_rd_res[0] - rr0, 0);
    consume(0);

    // Backpressure: response held while a new job waits
    done_after[0] = 1;
    start_job(0, 16'd9, 16'd11);
    wait_rsp(0, cyc);
    chk("t4_rsp_cycle", cyc, 13);
    req_a[0] = 16'd100;
    req_b[0] = 16'd200;
    req_valid[0] = 1'b1;
    act0 = act_cnt[0];
    for (int i = 0; i < 10; i++) begin
      chk("t4_hold_valid", 32'(rsp_valid[0]), 32'h1);
      chk("t4_hold_result", rsp_result[0], 32'd99);
      chk("t4_hold_req_ready", 32'(req_ready[0]), 32'h0);
      @(posedge clk); #1;
    end
    chk("t4_no_bus_activity", act_cnt[0] - act0, 0);
    s = wr_cnt[0];
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[0] = 1'b0;
    chk("t4_idle_after_hs", 32'(req_ready[0]), 32'h1);
    chk("t4_valid_after_hs", 32'(rsp_valid[0]), 32'h0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    chk("t4_new_job_busy", 32'(busy[0]), 32'h1);
    wait_rsp(0, cyc);
    chk("t4_new_rsp_cycle", cyc, 13);
    chk("t4_new_result", rsp_result[0], 32'd20000);
    chk_writes(0, s, 32'd100, 32'd200);
    consume(0);

    // Reset during the first poll gap
    start_job(0, 16'd12, 16'd13);
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("t5_in_gap_busy", 32'(busy[0]), 32'h1);
    chk("t5_in_gap_cs", 32'(bus_cs[0]), 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("t5_busy", 32'(busy[0]), 32'h0);
    chk("t5_rsp_valid", 32'(rsp_valid[0]), 32'h0);
    chk("t5_result", rsp_result[0], 32'h0);
    chk_idle_bus(0, "t5");
    act0 = act_cnt[0];
    repeat (20) begin
      @(posedge clk); #1;
    end
    chk("t5_no_strobes", act_cnt[0] - act0, 0);
    chk("t5_no_rsp", 32'(rsp_valid[0]), 32'h0);
    start_job(0, 16'd7, 16'd6);
    wait_rsp(0, cyc);
    chk("t5_rsp_cycle", cyc, 13);
    chk("t5_result_42", rsp_result[0], 32'd42);
    consume(0);

    // No-gap instance: operands change right after accept, rsp_ready held early
    s = wr_cnt[1];
    rsp_ready[1] = 1'b1;
    start_job(1, 16'h1234, 16'h0056);
    req_a[1] = 16'hAAAA;
    req_b[1] = 16'h5555;
    wait_rsp(1, cyc);
    chk("t6_rsp_cycle", cyc, 9);
    chk("t6_result", rsp_result[1], 32'h0006_1D78);
    chk("t6_timeout", 32'(rsp_timeout[1]), 32'h0);
    chk_writes(1, s, 32'h1234, 32'h0056);
    @(posedge clk); #1;
    rsp_ready[1] = 1'b0;
    chk("t6_valid_one_cycle", 32'(rsp_valid[1]), 32'h0);
    chk("t6_req_ready", 32'(req_ready[1]), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mult_bus_master.md
# mult_bus_master

Bus initiator that drives the memory-mapped multiplier peripheral from the other end of the peripheral bus. It accepts a 16x16 multiply job on a valid/ready request port and performs a fixed sequence of bus transactions: write A, write B, pulse init, poll done, read result. It returns the 32-bit product, or a timeout flag, on a valid/ready response port. It sits between an accelerator or test sequencer and the peripheral slot, in place of the CPU.

## Interface
- BASE_ADDR, 32'h0000_0000: peripheral base address. Register offsets are added to it: A 0x04, B 0x08, init 0x0C, result 0x10, done 0x14.
- POLL_GAP, 4: idle cycles before each done poll. 0 is legal and means no gap.
- TIMEOUT_POLLS, 1024: number of failed done polls before the job is abandoned. Must be ≥1.

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  job offered
- req_ready  out  1  job accepted when high with req_valid
- req_a  in  16  operand A, sampled at accept
- req_b  in  16  operand B, sampled at accept
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when high with rsp_valid
- rsp_result  out  32  product, or 0 on timeout
- rsp_timeout  out  1  job abandoned after TIMEOUT_POLLS failed polls
- busy  out  1  high in every state except IDLE
- bus_cs  out  1  peripheral select
- bus_addr  out  32  byte address
- bus_rd  out  1  read strobe
- bus_wr  out  1  write strobe
- bus_wdata  out  32  write data
- bus_rdata  in  32  peripheral read data; registered by the peripheral, valid the cycle after a read strobe

## Operation
- Moore FSM. All bus and handshake outputs are functions of the state register and the datapath registers only.
- When idle, all bus outputs are 0.
- States and actions:
  - IDLE: req_ready=1. On req_valid, latch a and b zero-extended to 32 bits, clear the poll counter, go to WR_A.
  - WR_A: cs=1, wr=1, addr=BASE+0x04, wdata={16'b0,a}. Next: WR_B.
  - WR_B: same form, addr=BASE+0x08, wdata={16'b0,b}. Next: INIT1.
  - INIT1: write 32'h1 to BASE+0x0C. Next: INIT0.
  - INIT0: write 32'h0 to BASE+0x0C. Next: GAP, or RD_DONE if POLL_GAP=0.
  - GAP: bus idle for POLL_GAP cycles, counted by the gap counter. Next: RD_DONE.
  - RD_DONE: cs=1, rd=1, addr=BASE+0x14. Next: CHK_DONE.
  - CHK_DONE: bus idle; sample bus_rdata[0].
    - If 1: go to RD_RES.
    - Else: increment the poll counter. If the counter reaches TIMEOUT_POLLS, set result=0, timeout=1, go to RESP. Otherwise go to GAP, or RD_DONE if POLL_GAP=0.
  - RD_RES: cs=1, rd=1, addr=BASE+0x10. Next: CAP_RES.
  - CAP_RES: latch bus_rdata into result, timeout=0. Next: RESP.
  - RESP: rsp_valid=1. rsp_result and rsp_timeout are held stable until rsp_ready. Next: IDLE on rsp_ready.
- Each write and each read is a single-cycle strobe. Strobes are never back-to-back on the same address except the two init writes.
- req_a and req_b are don't-care after the accept edge.
- The poll counter width is clog2(TIMEOUT_POLLS+1). It does not wrap.
- bus_rdata bits [31:1] are ignored during done polls.

## Timing
- Reset: state IDLE. req_ready=1. rsp_valid=0, rsp_result=0, rsp_timeout=0, busy=0. All bus outputs 0. Counters 0.
- Reset mid-job aborts on the next edge. No further strobes are issued and no response is produced.
- Cycle numbering: the accept edge ends cycle 0.
  - Cycles 1–4: WR_A, WR_B, INIT1, INIT0.
  - Cycles 5..4+G: gap, where G=POLL_GAP.
  - Cycle 5+G: done read strobe.
  - Cycle 6+G: done check.
- If done is seen on the first poll:
  - RD_RES in cycle 7+G, CAP_RES in 8+G.
  - rsp_valid first high in cycle 9+G (13 with defaults).
- Each failed poll adds G+2 cycles.
- Timeout response: rsp_valid first high at 5+TIMEOUT_POLLS·(G+2).
- req_ready is low from cycle 1 through the rsp handshake edge.
- A new job is accepted no earlier than the cycle after rsp_valid&&rsp_ready.
- rsp_ready held high before rsp_valid has no effect. The handshake completes in the first RESP cycle.

## Test plan
- Model peripheral, product ready immediately. Job A=3, B=5 -> writes 0x3 @0x04, 0x5 @0x08, 0x1 then 0x0 @0x0C. rsp_result=15, rsp_timeout=0, rsp_valid rises in cycle 13.
- Done asserted only on the 3rd poll, A=0xFFFF, B=0xFFFF -> exactly 3 reads of 0x14, one read of 0x10. rsp_result=0xFFFE0001, rsp_valid in cycle 25.
- TIMEOUT_POLLS=4, done stuck at 0 -> exactly 4 done reads, no result read. rsp_result=0, rsp_timeout=1, rsp_valid in cycle 29.
- rsp_ready held low 10 cycles after rsp_valid, with req_valid held high and new operands -> response stable, req_ready=0, no bus activity. New job starts the cycle after the handshake and uses the new operands.
- Reset asserted in the GAP of the first poll -> next cycle busy=0, all bus outputs 0, rsp_valid=0. A following job A=7, B=6 completes with result 42.
- Operands changed on the cycle after accept, POLL_GAP=0 -> written values are the accepted ones. rsp_valid in cycle 9.
